ff_mode_bank: RTL and testbench

Parametrised bank of WIDTH edge-triggered flip-flops with run-time selectable behaviour (JK, SR, D, T). It is the multi-bit, multi-mode successor to the single-bit master-slave JK flip-flop in the sequential-circuits library. It adds synchronous reset, clock enable, a latched mode register, per-bit change reporting and a sticky flag for illegal SR input. It is intended as the generic storage primitive for counters and shift structures built elsewhere in the library.

---
 rtl/ff_mode_pkg.sv | 9 +
 rtl/ff_mode_cell.sv | 38 +++
 rtl/ff_mode_bank.sv | 74 +++++++
 tb/tb_ff_mode_bank.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ff_mode_pkg.sv
// Shared mode encoding for the multi-mode flip-flop bank.
package ff_mode_pkg;
  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;
endpackage

// File: rtl/ff_mode_cell.sv
// Next-state logic for one flip-flop of the bank.
// Purely combinational; the bank owns the storage.
module ff_mode_cell
  import ff_mode_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       q,
  output logic       q_next,
  output logic       illegal
);
  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    case (mode_e'(mode))
      MODE_JK: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_SR: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   illegal = 1'b1;
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = a;
      MODE_T:  q_next = q ^ a;
      default: q_next = q;
    endcase
  end
endmodule

// File: rtl/ff_mode_bank.sv
// Bank of WIDTH flip-flops with run-time JK/SR/D/T mode,
// clock enable, change reporting and sticky SR error.
module ff_mode_bank
  import ff_mode_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_ld,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] chg,
  output logic             sr_err
);
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [1:0]       mode_q, mode_d;
  logic             sr_err_q, sr_err_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ill;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_mode_cell u_cell (
      .mode    (mode_q),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q_q[i]),
      .q_next  (nxt[i]),
      .illegal (ill[i])
    );
  end

  // Mode load ignores en; the cells still see the old mode this cycle.
  always_comb begin
    q_d      = q_q;
    chg_d    = '0;
    sr_err_d = sr_err_q;
    mode_d   = mode_ld ? mode_in : mode_q;
    if (en) begin
      q_d   = nxt;
      chg_d = nxt ^ q_q;
      if (|ill)        sr_err_d = 1'b1;
      else if (err_clr) sr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= RST_VAL;
      chg_q    <= '0;
      mode_q   <= MODE_JK;
      sr_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      chg_q    <= chg_d;
      mode_q   <= mode_d;
      sr_err_q <= sr_err_d;
    end
  end

  assign q      = q_q;
  assign qn     = ~q_q;
  assign mode   = mode_q;
  assign chg    = chg_q;
  assign sr_err = sr_err_q;
endmodule

// File: tb/tb_ff_mode_bank.sv
// Randomised and directed checks of ff_mode_bank
// against a behavioural model of the flip-flop rules.
module tb_ff_mode_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode_ld, err_clr;
  logic [1:0] mode_in, mode;
  logic [7:0] a, b, q, qn, chg;
  logic       sr_err;

  logic       rst1, en1, mode_ld1, err_clr1;
  logic [1:0] mode_in1, mode1;
  logic       a1, b1, q1, qn1, chg1, sr_err1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_q, m_chg;
  logic [1:0] m_mode;
  logic       m_err;
  logic       m1_q;

  ff_mode_bank #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode_ld(mode_ld),
    .mode_in(mode_in), .a(a), .b(b), .err_clr(err_clr),
    .q(q), .qn(qn), .mode(mode), .chg(chg), .sr_err(sr_err)
  );

  ff_mode_bank #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .mode_ld(mode_ld1),
    .mode_in(mode_in1), .a(a1), .b(b1), .err_clr(err_clr1),
    .q(q1), .qn(qn1), .mode(mode1), .chg(chg1), .sr_err(sr_err1)
  );

  // One flip-flop's behaviour: 0=JK 1=SR 2=D 3=T.
  function automatic logic bit_next(input logic [1:0] m,
                                    input logic x, input logic y,
                                    input logic cur);
    case (m)
      2'd0:    return (x && y) ? !cur : (x ? 1'b1 : (y ? 1'b0 : cur));
      2'd1:    return (x && !y) ? 1'b1 : ((!x && y) ? 1'b0 : cur);
      2'd2:    return x;
      default: return cur ^ x;
    endcase
  endfunction

  task automatic drive8(input logic r, input logic e, input logic ml,
                        input logic [1:0] mi, input logic [7:0] av,
                        input logic [7:0] bv, input logic ec);
    logic [7:0] nq;
    logic       bad;
    @(negedge clk);
    rst = r; en = e; mode_ld = ml; mode_in = mi;
    a = av; b = bv; err_clr = ec;
    @(posedge clk);
    #1;
    if (r) begin
      m_q = 8'hA5; m_chg = 8'h00; m_mode = 2'd0; m_err = 1'b0;
    end else begin
      nq  = m_q;
      bad = 1'b0;
      if (e) begin
        for (int i = 0; i < 8; i++) begin
          nq[i] = bit_next(m_mode, av[i], bv[i], m_q[i]);
          if (m_mode == 2'd1 && av[i] && bv[i]) bad = 1'b1;
        end
        m_chg = nq ^ m_q;
        m_q   = nq;
        if (bad)     m_err = 1'b1;
        else if (ec) m_err = 1'b0;
      end else begin
        m_chg = 8'h00;
      end
      if (ml) m_mode = mi;
    end
  endtask

  task automatic test_reset();
    drive8(1, 0, 0, 0, 8'h00, 8'h00, 0);
    vectors++;
    if ({q, qn, mode, chg, sr_err} !== {8'hA5, 8'h5A, 2'd0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset got q=%h qn=%h mode=%0d chg=%h err=%b want A5 5A 0 00 0",
               q, qn, mode, chg, sr_err);
    end
  endtask

  task automatic test_jk();
    drive8(0, 1, 0, 0, 8'hF0, 8'hCC, 0);
    vectors++;
    if ({q, qn, mode, chg, sr_err} !== {m_q, ~m_q, m_mode, m_chg, m_err}) begin
      miscompares++;
      $display("FAIL jk got q=%h chg=%h want q=%h chg=%h", q, chg, m_q, m_chg);
    end
  endtask

  task automatic test_sr_err();
    logic [7:0] av [4] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
    logic       ml [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       ec [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive8(0, 1, ml[k], 2'd1, av[k], av[k], ec[k]);
      vectors++;
      if ({q, qn, mode, chg, sr_err} !== {m_q, ~m_q, m_mode, m_chg, m_err}) begin
        miscompares++;
        $display("FAIL sr_step%0d got q=%h mode=%0d chg=%h err=%b want q=%h mode=%0d chg=%h err=%b",
                 k, q, mode, chg, sr_err, m_q, m_mode, m_chg, m_err);
      end
    end
  endtask

  task automatic test_t_mode();
    drive8(0, 1, 1, 2'd2, 8'h00, 8'h00, 0);
    drive8(0, 1, 1, 2'd3, 8'h00, 8'h00, 0);
    for (int k = 0; k < 5; k++) begin
      drive8(0, (k < 4), 0, 2'd0, 8'h01, 8'h00, 0);
      vectors++;
      if ({q, qn, mode, chg, sr_err} !== {m_q, ~m_q, m_mode, m_chg, m_err}) begin
        miscompares++;
        $display("FAIL t_step%0d got q=%h chg=%h mode=%0d want q=%h chg=%h mode=%0d",
                 k, q, chg, mode, m_q, m_chg, m_mode);
      end
    end
  endtask

  task automatic test_d_reset();
    drive8(0, 0, 1, 2'd2, 8'h00, 8'h00, 0);
    drive8(1, 1, 1, 2'd2, 8'h3C, 8'h00, 1);
    vectors++;
    if ({q, mode, chg, sr_err} !== {8'hA5, 2'd0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL d_rst got q=%h mode=%0d chg=%h want A5 0 00", q, mode, chg);
    end
    drive8(0, 1, 0, 2'd0, 8'h3C, 8'h00, 0);
    vectors++;
    if ({q, qn, mode, chg, sr_err} !== {m_q, ~m_q, m_mode, m_chg, m_err}) begin
      miscompares++;
      $display("FAIL d_after_rst got q=%h chg=%h want q=%h chg=%h", q, chg, m_q, m_chg);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      drive8(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0), 2'($urandom),
             8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      vectors++;
      if ({q, qn, mode, chg, sr_err} !== {m_q, ~m_q, m_mode, m_chg, m_err}) begin
        miscompares++;
        $display("FAIL rand%0d got q=%h qn=%h mode=%0d chg=%h err=%b want q=%h mode=%0d chg=%h err=%b",
                 k, q, qn, mode, chg, sr_err, m_q, m_mode, m_chg, m_err);
      end
    end
  endtask

  task automatic test_width1();
    logic [1:0] jk [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    logic       prev;
    @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    m1_q = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst1 = 1'b0; en1 = 1'b1;
      {a1, b1} = jk[k];
      @(posedge clk);
      #1;
      prev = m1_q;
      m1_q = bit_next(2'd0, jk[k][1], jk[k][0], m1_q);
      vectors++;
      if ({q1, qn1, chg1} !== {m1_q, ~m1_q, m1_q ^ prev}) begin
        miscompares++;
        $display("FAIL w1_step%0d got q=%b qn=%b chg=%b want q=%b qn=%b",
                 k, q1, qn1, chg1, m1_q, ~m1_q);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode_ld = 1'b0; mode_in = 2'd0;
    a = '0; b = '0; err_clr = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; mode_ld1 = 1'b0; mode_in1 = 2'd0;
    a1 = 1'b0; b1 = 1'b0; err_clr1 = 1'b0;
    m_q = 8'hA5; m_chg = 8'h00; m_mode = 2'd0; m_err = 1'b0;
    m1_q = 1'b0;
    test_reset();
    test_jk();
    test_sr_err();
    test_t_mode();
    test_d_reset();
    test_random();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
